// File: rtl/raymarch_pkg.sv
// Shared fixed-point types, defaults and FSM state encoding for the ray marcher.
package raymarch_pkg;

  localparam int FRAC_BITS = 10;

  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam fixed_t HIT_EPS_DEF  = 32'sd16;      // 1/64
  localparam fixed_t MAX_DIST_DEF = 32'sd102400;  // 100.0

  // Whole-number to Q21.10 conversion.
  function automatic fixed_t to_fixed(input int whole);
    return fixed_t'(whole <<< FRAC_BITS);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EVAL,
    ST_FINISH
  } march_state_t;

endpackage

// File: rtl/fixed_mul.sv
// Q21.10 multiply: full 64-bit signed product, arithmetic shift back to Q21.10,
// truncated to 32 bits (wraps silently on overflow).
module fixed_mul
  import raymarch_pkg::*;
(
  input  fixed_t i_a,
  input  fixed_t i_b,
  output fixed_t o_p
);

  assign o_p = fixed_t'((64'(i_a) * 64'(i_b)) >>> FRAC_BITS);

endmodule

// File: rtl/ray_march_ctrl.sv
// Ray-march sequencer: drives one SDF query per step and advances the sample
// point along the ray until a hit, the travel limit or the step limit.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for ray_start; result outputs hold
// ST_ISSUE  | sdf_start strobe for the current sample point
// ST_WAIT   | waiting for sdf_done; captures distance and colour
// ST_EVAL   | hit / step-limit / distance-limit decision, or advance
// ST_FINISH | ray_done pulse, result valid
module ray_march_ctrl
  import raymarch_pkg::*;
#(
  parameter int     MAX_STEPS = 64,
  parameter fixed_t HIT_EPS   = HIT_EPS_DEF,
  parameter fixed_t MAX_DIST  = MAX_DIST_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ray_start,
  input  logic [31:0] origin_x,
  input  logic [31:0] origin_y,
  input  logic [31:0] origin_z,
  input  logic [31:0] dir_x,
  input  logic [31:0] dir_y,
  input  logic [31:0] dir_z,
  output logic        ray_busy,
  output logic        ray_done,
  output logic        ray_hit,
  output logic [7:0]  step_count,
  output logic [31:0] total_dist,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        sdf_start,
  output logic [31:0] sdf_x,
  output logic [31:0] sdf_y,
  output logic [31:0] sdf_z,
  input  logic        sdf_done,
  input  logic signed [31:0] sdf_out,
  input  logic [7:0]  sdf_red_out,
  input  logic [7:0]  sdf_green_out,
  input  logic [7:0]  sdf_blue_out
);

  march_state_t r_state;
  march_state_t w_state_nxt;

  vec3_t  r_pos;
  vec3_t  r_dir;
  fixed_t r_dist;
  rgb_t   r_sdf_rgb;
  rgb_t   r_rgb;
  logic [7:0] r_step;
  fixed_t r_total;
  logic   r_hit;

  vec3_t  w_delta;
  logic signed [32:0] w_sum;
  logic   w_hit;
  logic   w_step_lim;
  logic   w_dist_lim;
  logic   w_sdf_start;
  logic   w_busy;
  logic   w_done;

  fixed_mul u_mul_x (.i_a(r_dir.x), .i_b(r_dist), .o_p(w_delta.x));
  fixed_mul u_mul_y (.i_a(r_dir.y), .i_b(r_dist), .o_p(w_delta.y));
  fixed_mul u_mul_z (.i_a(r_dir.z), .i_b(r_dist), .o_p(w_delta.z));

  // 33-bit sum so the travel-limit compare cannot wrap.
  assign w_sum      = 33'(r_total) + 33'(r_dist);
  assign w_hit      = (r_dist < HIT_EPS);
  assign w_step_lim = (r_step == 8'(MAX_STEPS));
  assign w_dist_lim = (w_sum >= 33'(MAX_DIST));

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_sdf_start = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ray_start) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_busy      = 1'b1;
        w_sdf_start = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (sdf_done) w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        w_busy = 1'b1;
        if (w_hit || w_step_lim || w_dist_lim) w_state_nxt = ST_FINISH;
        else                                   w_state_nxt = ST_ISSUE;
      end
      ST_FINISH: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: ray capture, SDF result capture, and step advance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pos     <= '0;
      r_dir     <= '0;
      r_dist    <= '0;
      r_sdf_rgb <= '0;
      r_rgb     <= '0;
      r_step    <= '0;
      r_total   <= '0;
      r_hit     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ray_start) begin
            r_pos   <= '{x: origin_x, y: origin_y, z: origin_z};
            r_dir   <= '{x: dir_x, y: dir_y, z: dir_z};
            r_step  <= '0;
            r_total <= '0;
            r_hit   <= 1'b0;
            r_rgb   <= '0;
          end
        end
        ST_WAIT: begin
          if (sdf_done) begin
            r_dist    <= sdf_out;
            r_sdf_rgb <= '{r: sdf_red_out, g: sdf_green_out, b: sdf_blue_out};
            r_step    <= r_step + 8'd1;
          end
        end
        ST_EVAL: begin
          if (w_hit) begin
            r_hit <= 1'b1;
            r_rgb <= r_sdf_rgb;
          end else if (!w_step_lim && !w_dist_lim) begin
            r_pos.x <= r_pos.x + w_delta.x;
            r_pos.y <= r_pos.y + w_delta.y;
            r_pos.z <= r_pos.z + w_delta.z;
            r_total <= w_sum[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign ray_busy   = w_busy;
  assign ray_done   = w_done;
  assign sdf_start  = w_sdf_start;
  assign ray_hit    = r_hit;
  assign step_count = r_step;
  assign total_dist = r_total;
  assign red_out    = r_rgb.r;
  assign green_out  = r_rgb.g;
  assign blue_out   = r_rgb.b;
  assign sdf_x      = r_pos.x;
  assign sdf_y      = r_pos.y;
  assign sdf_z      = r_pos.z;

endmodule

// File: tb/tb_ray_march_ctrl.sv
// Bench for ray_march_ctrl: SDF stub with programmable latency, a march model
// computed directly from the stepping rules, and a per-cycle compare process.
module tb_ray_march_ctrl;
  import raymarch_pkg::*;

  localparam int     MAXS = 64;
  localparam int     HIT  = 16;
  localparam longint MAXD = 102400;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ray_start;
  logic [31:0] origin_x, origin_y, origin_z;
  logic [31:0] dir_x, dir_y, dir_z;
  logic        ray_busy, ray_done, ray_hit;
  logic [7:0]  step_count;
  logic [31:0] total_dist;
  logic [7:0]  red_out, green_out, blue_out;
  logic        sdf_start;
  logic [31:0] sdf_x, sdf_y, sdf_z;
  logic        sdf_done;
  logic signed [31:0] sdf_out;
  logic [7:0]  sdf_red_out, sdf_green_out, sdf_blue_out;

  always #5 clk_in = ~clk_in;

  ray_march_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .ray_start(ray_start),
    .origin_x(origin_x), .origin_y(origin_y), .origin_z(origin_z),
    .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
    .ray_busy(ray_busy), .ray_done(ray_done), .ray_hit(ray_hit),
    .step_count(step_count), .total_dist(total_dist),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .sdf_start(sdf_start), .sdf_x(sdf_x), .sdf_y(sdf_y), .sdf_z(sdf_z),
    .sdf_done(sdf_done), .sdf_out(sdf_out),
    .sdf_red_out(sdf_red_out), .sdf_green_out(sdf_green_out), .sdf_blue_out(sdf_blue_out)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // stub configuration
  int       stub_mode = 1;
  int       stub_c    = 0;
  int       stub_L    = 1;
  logic [7:0] stub_r = 0, stub_g = 0, stub_b = 0;
  bit       inj_issue = 0;
  int       inj_req = 0;

  // model expectations
  bit     exp_active = 0;
  int     start_cyc  = 0;
  int     exp_lat, exp_steps, exp_hit;
  longint exp_total;
  int     exp_r, exp_g, exp_b;
  int     qx[$], qy[$], qz[$];
  int     done_cnt = 0;
  int     act_steps, act_hit, act_lat, act_r, act_g, act_b;
  longint act_total;
  int     last_qz;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sdf_fn(input int x, input int y, input int z);
    int ax, az;
    ax = (x < 0) ? -x : x;
    az = (z < 0) ? -z : z;
    case (stub_mode)
      0: return az;
      1: return stub_c;
      2: return (ax + az + ((y < 0) ? -y : y)) >>> 1;
      default: return 0;
    endcase
  endfunction

  // March the ray by the rules: query, count, hit/limit tests, then advance.
  task automatic model_ray(input int ox, oy, oz, dx, dy, dz);
    int px, py, pz, d, n;
    longint tot;
    bit fin;
    px = ox; py = oy; pz = oz; n = 0; tot = 0; fin = 0;
    exp_hit = 0; exp_r = 0; exp_g = 0; exp_b = 0;
    qx.delete(); qy.delete(); qz.delete();
    while (!fin) begin
      qx.push_back(px); qy.push_back(py); qz.push_back(pz);
      d = sdf_fn(px, py, pz);
      n++;
      if (d < HIT) begin
        exp_hit = 1; exp_r = stub_r; exp_g = stub_g; exp_b = stub_b; fin = 1;
      end else if (n == MAXS) begin
        fin = 1;
      end else if (tot + longint'(d) >= MAXD) begin
        fin = 1;
      end else begin
        px = px + int'((longint'(dx) * longint'(d)) >>> 10);
        py = py + int'((longint'(dy) * longint'(d)) >>> 10);
        pz = pz + int'((longint'(dz) * longint'(d)) >>> 10);
        tot = tot + longint'(d);
      end
    end
    exp_steps = n;
    exp_total = tot;
    exp_lat   = 1 + n * (stub_L + 2);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk_in);
    cyc = cyc + 1;
  end

  // SDF stub: answers each sdf_start stub_L cycles later; colour is only
  // meaningful in the done cycle.
  initial begin
    int cnt, res, seen;
    cnt = 0; res = 0; seen = 0;
    sdf_done = 0; sdf_out = 0;
    sdf_red_out = 8'h55; sdf_green_out = 8'h55; sdf_blue_out = 8'h55;
    forever begin
      @(posedge clk_in);
      #1;
      sdf_done = 0;
      sdf_out  = 32'sh7fff_0000;
      sdf_red_out = 8'h55; sdf_green_out = 8'h55; sdf_blue_out = 8'h55;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sdf_done = 1; sdf_out = res;
          sdf_red_out = stub_r; sdf_green_out = stub_g; sdf_blue_out = stub_b;
        end
      end
      if (sdf_start) begin
        cnt = stub_L;
        res = sdf_fn(int'(sdf_x), int'(sdf_y), int'(sdf_z));
        if (inj_issue) begin sdf_done = 1; sdf_out = 0; end
      end
      if (inj_req != seen) begin
        seen = inj_req;
        sdf_done = 1; sdf_out = 0;
      end
    end
  end

  // Compare process.
  initial forever begin
    @(negedge clk_in);
    if (exp_active && cyc > start_cyc && cyc <= start_cyc + exp_lat)
      chk("busy", ray_busy, 1);
    if (exp_active && sdf_start) begin
      if (qz.size() == 0) chk("extra_query", 1, 0);
      else begin
        last_qz = qz[0];
        chk("query_x", int'(sdf_x), qx.pop_front());
        chk("query_y", int'(sdf_y), qy.pop_front());
        chk("query_z", int'(sdf_z), qz.pop_front());
      end
    end
    if (ray_done) begin
      if (!exp_active) chk("unexpected_done", 1, 0);
      else begin
        act_hit = ray_hit; act_steps = step_count; act_total = total_dist;
        act_r = red_out; act_g = green_out; act_b = blue_out;
        act_lat = cyc - start_cyc;
        chk("hit", act_hit, exp_hit);
        chk("steps", act_steps, exp_steps);
        chk("total", act_total, exp_total);
        chk("red", act_r, exp_r);
        chk("green", act_g, exp_g);
        chk("blue", act_b, exp_b);
        chk("latency", act_lat, exp_lat);
        chk("queries_left", qz.size(), 0);
        done_cnt++;
      end
    end
  end

  task automatic run_ray(input int ox, oy, oz, dx, dy, dz, input bit poke);
    int dc;
    bit got;
    model_ray(ox, oy, oz, dx, dy, dz);
    @(negedge clk_in);
    origin_x = ox; origin_y = oy; origin_z = oz;
    dir_x = dx; dir_y = dy; dir_z = dz;
    dc = done_cnt;
    start_cyc = cyc;
    exp_active = 1;
    ray_start = 1;
    @(negedge clk_in);
    ray_start = 0;
    origin_x = 32'h1234_5678; dir_x = 32'h0000_0400;
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      if (poke && (i == 4 || i == 9)) begin
        ray_start = 1; origin_z = 32'h0000_0000; dir_z = 32'hffff_fc00;
      end else ray_start = 0;
      @(negedge clk_in);
      if (done_cnt != dc) got = 1;
    end
    ray_start = 0;
    if (!got) chk("done_timeout", 0, 1);
    exp_active = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("hold_steps", step_count, exp_steps);
    chk("hold_busy", ray_busy, 0);
  endtask

  initial begin
    int ox, oy, oz, dx, dy, dz;
    rst_in = 1; ray_start = 0;
    origin_x = 0; origin_y = 0; origin_z = 0;
    dir_x = 0; dir_y = 0; dir_z = 0;
    repeat (3) @(negedge clk_in);
    rst_in = 0;
    @(negedge clk_in);
    // reset state
    chk("rst_busy", ray_busy, 0);
    chk("rst_done", ray_done, 0);
    chk("rst_hit", ray_hit, 0);
    chk("rst_steps", step_count, 0);
    chk("rst_total", total_dist, 0);
    chk("rst_rgb", {red_out, green_out, blue_out}, 0);
    chk("rst_start", sdf_start, 0);
    chk("rst_pos", {sdf_x, sdf_y, sdf_z}, 0);

    // spurious sdf_done in IDLE
    inj_req++;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("idle_done_busy", ray_busy, 0);
    chk("idle_done_steps", step_count, 0);

    // plane hit
    stub_mode = 0; stub_L = 3; stub_r = 11; stub_g = 22; stub_b = 33;
    run_ray(0, 0, -to_fixed(10), 0, 0, to_fixed(1), 0);
    chk("plane_hit", act_hit, 1);
    chk("plane_steps", act_steps, 2);
    chk("plane_total", act_total, 10240);
    chk("plane_q2_z", last_qz, 0);
    chk("plane_latency", act_lat, 11);

    // distance miss
    stub_mode = 1; stub_c = to_fixed(30); stub_L = 2;
    run_ray(0, 0, 0, to_fixed(1), 0, 0, 0);
    chk("dmiss_hit", act_hit, 0);
    chk("dmiss_steps", act_steps, 4);
    chk("dmiss_total", act_total, 92160);
    chk("dmiss_rgb", act_r + act_g + act_b, 0);

    // step limit, with ray_start pokes while busy
    stub_c = to_fixed(1); stub_L = 1;
    run_ray(0, 0, 0, 0, to_fixed(1), 0, 1);
    chk("slim_hit", act_hit, 0);
    chk("slim_steps", act_steps, 64);
    chk("slim_total", act_total, 64512);

    // negative distance, colour, spurious done in ISSUE
    stub_c = -512; stub_L = 4; stub_r = 200; stub_g = 10; stub_b = 30;
    run_ray(100, 200, 300, 0, 0, to_fixed(1), 0);
    chk("neg_hit", act_hit, 1);
    chk("neg_steps", act_steps, 1);
    chk("neg_rgb", {8'(act_r), 8'(act_g), 8'(act_b)}, {8'd200, 8'd10, 8'd30});
    inj_issue = 1;
    stub_c = to_fixed(40); stub_L = 3;
    run_ray(0, 0, 0, to_fixed(1), 0, 0, 0);
    chk("issue_inj_steps", act_steps, 3);
    inj_issue = 0;

    // randomized rays
    for (int t = 0; t < 12; t++) begin
      stub_L    = $urandom_range(1, 5);
      stub_mode = $urandom_range(0, 2);
      stub_c    = $urandom_range(0, 40960);
      stub_r = 8'($urandom); stub_g = 8'($urandom); stub_b = 8'($urandom);
      ox = int'($urandom_range(0, 4096)) - 2048;
      oy = int'($urandom_range(0, 4096)) - 2048;
      oz = -int'($urandom_range(1024, 30720));
      dx = int'($urandom_range(0, 400)) - 200;
      dy = int'($urandom_range(0, 400)) - 200;
      dz = int'($urandom_range(256, 1024));
      run_ray(ox, oy, oz, dx, dy, dz, (t % 4) == 1);
    end

    // reset mid-WAIT, then a late sdf_done must be ignored
    stub_mode = 1; stub_c = to_fixed(1); stub_L = 12;
    @(negedge clk_in);
    origin_x = 32'h0000_1000; origin_y = 32'h0000_2000; origin_z = 32'h0000_3000;
    ray_start = 1;
    @(negedge clk_in);
    ray_start = 0;
    repeat (4) @(negedge clk_in);
    chk("midwait_busy", ray_busy, 1);
    rst_in = 1;
    @(negedge clk_in);
    rst_in = 0;
    chk("mrst_busy", ray_busy, 0);
    chk("mrst_pos", {sdf_x, sdf_y, sdf_z}, 0);
    chk("mrst_steps", step_count, 0);
    chk("mrst_start", sdf_start, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      chk("late_busy", ray_busy, 0);
      chk("late_steps", step_count, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
